// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
package register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file.
// x0 always reads zero. When REGISTER_FILE_BYPASS_EN is defined, a write
// to the same register in the current cycle is forwarded to the output;
// otherwise the stored value is shown until the write edge.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [XLEN-1:0]   regs [1:(2**ADDR_W)-1],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              reset,
    output logic [XLEN-1:0]   rd_data
);

    localparam int NUM = 2**ADDR_W;

    logic [XLEN-1:0] stored_s;

    // One-hot OR mux over x1..x(NUM-1); index 0 matches nothing and yields zero.
    always_comb begin
        stored_s = {XLEN{1'b0}};
        for (int i = 1; i < NUM; i++) begin
            stored_s = stored_s | ((rd_idx == ADDR_W'(i)) ? regs[i] : {XLEN{1'b0}});
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    logic bypass_hit_s;

    // Forward the in-flight write data when it targets this port's index;
    // never for x0 and never while the file is held in reset.
    always_comb begin
        bypass_hit_s = wr_en && !reset && (wr_addr == rd_idx) &&
                       (rd_idx != ADDR_W'(ZERO_REG));
        if (bypass_hit_s) begin
            rd_data = wr_data;
        end else begin
            rd_data = stored_s;
        end
    end
`else
    logic unused_bypass_s;
    assign unused_bypass_s = ^{wr_en, wr_addr, wr_data, reset};

    // Without forwarding the port simply shows stored contents.
    always_comb begin
        rd_data = stored_s;
    end
`endif

endmodule : register_file_read_port

// File: rtl/register_file.sv
// RV32I integer register file: 31 storage registers (x1..x31), x0 hardwired
// to zero, two combinational read ports and one clocked write port.
// Asynchronous active-high reset clears all storage.
// Optional macro: REGISTER_FILE_BYPASS_EN enables write-to-read forwarding.
module register_file
    import register_file_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic [XLEN-1:0]   rs1_out,
    output logic [XLEN-1:0]   rs2_out,
    input  logic              enable,
    input  logic [XLEN-1:0]   data
);

    localparam int NUM = 2**ADDR_W;

    logic [XLEN-1:0] regs_r [1:NUM-1];
    logic            write_hit_s;

    // A write is only real when enabled and not aimed at x0.
    always_comb begin
        write_hit_s = enable && (rd != ADDR_W'(ZERO_REG));
    end

    // Storage update: reset clears everything immediately and blocks writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM; i++) begin
                if (write_hit_s && (rd == ADDR_W'(i))) begin
                    regs_r[i] <= data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    register_file_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_read_port_1 (
        .rd_idx  (rs1),
        .regs    (regs_r),
        .wr_en   (enable),
        .wr_addr (rd),
        .wr_data (data),
        .reset   (reset),
        .rd_data (rs1_out)
    );

    register_file_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_read_port_2 (
        .rd_idx  (rs2),
        .regs    (regs_r),
        .wr_en   (enable),
        .wr_addr (rd),
        .wr_data (data),
        .reset   (reset),
        .rd_data (rs2_out)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file.
`timescale 1ns/1ps
module tb_register_file;
    import register_file_pkg::*;

    logic      clk;
    logic      reset;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    xlen_t     rs1_out;
    xlen_t     rs2_out;
    logic      enable;
    xlen_t     data;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        xlen_t     wd;
        reg_addr_t ra1;
        reg_addr_t ra2;
        xlen_t     exp1;
        xlen_t     exp2;
    } vec_t;

    vec_t vecs [11];

    register_file #(.XLEN(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .rs1_out (rs1_out),
        .rs2_out (rs2_out),
        .enable  (enable),
        .data    (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input xlen_t act, input xlen_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic xlen_t fill_val(input int i);
        return xlen_t'(i) * 32'h01010101;
    endfunction

    initial begin
        xlen_t exp_bypass;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd1,  5'd2,  32'h01010101, 32'h02020202};
        vecs[1]  = '{1'b0, 5'd7,  32'hCAFEBABE, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b0, 5'd7,  32'hCAFEBABE, 5'd7,  5'd0,  32'h12345678, 32'h00000000};
        vecs[3]  = '{1'b0, 5'd7,  32'h00000000, 5'd7,  5'd8,  32'h12345678, 32'h08080808};
        vecs[4]  = '{1'b1, 5'd8,  32'hA5A5A5A5, 5'd7,  5'd9,  32'h12345678, 32'h09090909};
        vecs[5]  = '{1'b1, 5'd9,  32'h5A5A5A5A, 5'd8,  5'd7,  32'hA5A5A5A5, 32'h12345678};
        vecs[6]  = '{1'b0, 5'd0,  32'h00000000, 5'd9,  5'd8,  32'h5A5A5A5A, 32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd29, 32'h1E1E1E1E, 32'h1D1D1D1D};
        vecs[8]  = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{1'b1, 5'd0,  32'h12121212, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vecs[10] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd31, 32'h01010101, 32'hFFFFFFFF};

        // Reset held: all indices read zero, writes ignored.
        reset  = 1'b1;
        enable = 1'b1;
        rd     = 5'd5;
        data   = 32'hDEADBEEF;
        rs1    = 5'd0;
        rs2    = 5'd0;
        #2;
        for (int i = 0; i < 32; i++) begin
            rs1 = reg_addr_t'(i);
            rs2 = reg_addr_t'(31 - i);
            #1;
            check("reset_rs1", rs1_out, 32'h0);
            check("reset_rs2", rs2_out, 32'h0);
        end
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        rs1    = 5'd5;
        #1;
        check("reset_write_ignored_x5", rs1_out, 32'h0);

        // Fill x1..x31.
        rs1 = 5'd0;
        rs2 = 5'd0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            rd     = reg_addr_t'(i);
            data   = fill_val(i);
            enable = 1'b1;
        end
        @(negedge clk);
        enable = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rs1 = reg_addr_t'(i);
            rs2 = reg_addr_t'(i);
            #0.1;
            check("fill_rs1", rs1_out, fill_val(i));
            check("fill_rs2", rs2_out, fill_val(i));
        end

        // x0 is immutable and a write to it touches nothing else.
        @(negedge clk);
        rd     = 5'd0;
        data   = 32'hFFFFFFFF;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        rs1    = 5'd0;
        rs2    = 5'd1;
        #1;
        check("x0_reads_zero", rs1_out, 32'h0);
        check("x0_write_no_side_effect", rs2_out, 32'h01010101);

        // Table: reads checked before each edge, then the write commits.
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            enable = vecs[v].we;
            rd     = vecs[v].wa;
            data   = vecs[v].wd;
            rs1    = vecs[v].ra1;
            rs2    = vecs[v].ra2;
            #1;
            check($sformatf("vec%0d_rs1", v), rs1_out, vecs[v].exp1);
            check($sformatf("vec%0d_rs2", v), rs2_out, vecs[v].exp2);
        end

        // Same-cycle read of the register being written.
        @(negedge clk);
        enable = 1'b1;
        rd     = 5'd3;
        data   = 32'h11111111;
        rs1    = 5'd0;
        rs2    = 5'd0;
        @(negedge clk);
        data = 32'h22222222;
        rs1  = 5'd3;
        rs2  = 5'd0;
`ifdef REGISTER_FILE_BYPASS_EN
        exp_bypass = 32'h22222222;
`else
        exp_bypass = 32'h11111111;
`endif
        #1;
        check("same_cycle_rs1", rs1_out, exp_bypass);
        check("same_cycle_x0", rs2_out, 32'h0);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("after_edge_rs1", rs1_out, 32'h22222222);

        // Write to x0 with rs=0 never forwards.
        enable = 1'b1;
        rd     = 5'd0;
        data   = 32'h77777777;
        rs1    = 5'd0;
        #1;
        check("x0_no_bypass", rs1_out, 32'h0);
        enable = 1'b0;

        // Async reset mid-cycle with a pending write to x4.
        @(negedge clk);
        rs1 = 5'd4;
        #1;
        check("pre_reset_x4", rs1_out, 32'h04040404);
        enable = 1'b1;
        rd     = 5'd4;
        data   = 32'h44444444;
        reset  = 1'b1;
        #0.1;
        check("reset_bypass_blocked", rs1_out, 32'h0);
        for (int i = 1; i < 32; i++) begin
            rs1 = reg_addr_t'(i);
            rs2 = reg_addr_t'(32 - i);
            #0.1;
            check("async_reset_rs1", rs1_out, 32'h0);
            check("async_reset_rs2", rs2_out, 32'h0);
        end
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        rs1    = 5'd4;
        rs2    = 5'd22;
        #1;
        check("reset_won_x4", rs1_out, 32'h0);
        check("reset_cleared_x22", rs2_out, 32'h0);

        // First edge after reset release accepts a write.
        enable = 1'b1;
        rd     = 5'd22;
        data   = 32'h0BADF00D;
        rs2    = 5'd0;
        @(negedge clk);
        enable = 1'b0;
        rs2    = 5'd22;
        #1;
        check("first_write_after_reset", rs2_out, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_register_file
